// File: rtl/ensemble_vote_controller.sv
// ---------------------------------------------------------------------------
// ensemble_vote_controller
//
// Purpose:
//   Front-end sequencer and majority voter for a three-classifier ensemble
//   (Gaussian NB, logistic regression, MLP). One feature packet arrives on
//   the slave stream. Each beat is broadcast to all three classifier input
//   streams, and each branch has its own handshake. The block then collects
//   one result packet per classifier and votes on the three class labels.
//   It emits the result as a single-beat decision packet.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   s_axis_*               feature stream in (tdata/tkeep/tvalid/tready/tlast)
//   m_axis_*_0/1/2         feature stream out to classifier 0/1/2
//   s_axis_res_*_0/1/2     result stream in from classifier 0/1/2
//   m_axis_dec_*           voted decision out:
//                            tdata[CLASS_WIDTH-1:0]           = winning label
//                            tdata[CLASS_WIDTH+1:CLASS_WIDTH] = agree count
//   busy                   high whenever the controller is not idle
//
// Optional build macro:
//   ENS_STATS_EN  adds the stat_pkts / stat_split / stat_tie decision
//                 counters and their output ports.
// ---------------------------------------------------------------------------
module ensemble_vote_controller #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = 8,
    parameter int TIE_SEL     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,

    output logic [DATA_WIDTH-1:0] m_axis_tdata_0,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep_0,
    output logic                  m_axis_tvalid_0,
    input  logic                  m_axis_tready_0,
    output logic                  m_axis_tlast_0,

    output logic [DATA_WIDTH-1:0] m_axis_tdata_1,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep_1,
    output logic                  m_axis_tvalid_1,
    input  logic                  m_axis_tready_1,
    output logic                  m_axis_tlast_1,

    output logic [DATA_WIDTH-1:0] m_axis_tdata_2,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep_2,
    output logic                  m_axis_tvalid_2,
    input  logic                  m_axis_tready_2,
    output logic                  m_axis_tlast_2,

    input  logic [DATA_WIDTH-1:0] s_axis_res_tdata_0,
    input  logic [KEEP_WIDTH-1:0] s_axis_res_tkeep_0,
    input  logic                  s_axis_res_tvalid_0,
    output logic                  s_axis_res_tready_0,
    input  logic                  s_axis_res_tlast_0,

    input  logic [DATA_WIDTH-1:0] s_axis_res_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_res_tkeep_1,
    input  logic                  s_axis_res_tvalid_1,
    output logic                  s_axis_res_tready_1,
    input  logic                  s_axis_res_tlast_1,

    input  logic [DATA_WIDTH-1:0] s_axis_res_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_res_tkeep_2,
    input  logic                  s_axis_res_tvalid_2,
    output logic                  s_axis_res_tready_2,
    input  logic                  s_axis_res_tlast_2,

    output logic [DATA_WIDTH-1:0] m_axis_dec_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_dec_tkeep,
    output logic                  m_axis_dec_tvalid,
    input  logic                  m_axis_dec_tready,
    output logic                  m_axis_dec_tlast,

`ifdef ENS_STATS_EN
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_split,
    output logic [31:0]           stat_tie,
`endif

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BCAST   = 2'd1,
        COLLECT = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    localparam logic [1:0] TIE_IDX = 2'(TIE_SEL);

    state_t                       state_q, state_d;
    // Low for the first cycle after reset release; it holds off
    // s_axis_tready until reset has been synchronously deasserted.
    logic                         run_q;

    logic [DATA_WIDTH-1:0]        beat_data_q, beat_data_d;
    logic [KEEP_WIDTH-1:0]        beat_keep_q, beat_keep_d;
    logic                         beat_last_q, beat_last_d;
    logic [2:0]                   sent_mask_q, sent_mask_d;

    logic [2:0]                   res_got_q, res_got_d;
    logic [2:0]                   res_done_q, res_done_d;
    logic [2:0][CLASS_WIDTH-1:0]  label_q, label_d;

    logic [DATA_WIDTH-1:0]        dec_data_q, dec_data_d;

    logic [2:0]                   m_tvalid, m_tready, m_acc;
    logic [2:0]                   r_tvalid, r_tready, r_tlast, r_acc;
    logic [2:0][DATA_WIDTH-1:0]   r_tdata;
    logic                         s_tready, s_acc, dec_acc;

    // Only the label bits of the first result beat carry information.
    // Result keeps and upper data bits are intentionally ignored.
    logic                         unused_res_inputs;
    assign unused_res_inputs = ^{s_axis_res_tkeep_0, s_axis_res_tkeep_1,
                                 s_axis_res_tkeep_2, r_tdata};

    // Majority vote. If two or more labels match, that label wins. If all
    // three labels differ, the tie-break classifier's label is used.
    function automatic logic [CLASS_WIDTH+1:0] vote(
        input logic [2:0][CLASS_WIDTH-1:0] lbl
    );
        logic [CLASS_WIDTH+1:0] res;
        if ((lbl[0] == lbl[1]) && (lbl[0] == lbl[2])) begin
            res = {2'd3, lbl[0]};
        end else if ((lbl[0] == lbl[1]) || (lbl[0] == lbl[2])) begin
            res = {2'd2, lbl[0]};
        end else if (lbl[1] == lbl[2]) begin
            res = {2'd2, lbl[1]};
        end else begin
            res = {2'd1, lbl[TIE_IDX]};
        end
        return res;
    endfunction

    assign m_tready = {m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};
    assign r_tvalid = {s_axis_res_tvalid_2, s_axis_res_tvalid_1, s_axis_res_tvalid_0};
    assign r_tlast  = {s_axis_res_tlast_2, s_axis_res_tlast_1, s_axis_res_tlast_0};
    assign r_tdata  = {s_axis_res_tdata_2, s_axis_res_tdata_1, s_axis_res_tdata_0};

    // Branch valids come only from registered state, never from tready.
    assign m_tvalid = (state_q == BCAST)   ? ~sent_mask_q : 3'b000;
    assign r_tready = (state_q == COLLECT) ? ~res_done_q  : 3'b000;

    // In BCAST a new beat is taken only once the previous beat has been
    // delivered to every branch (mask already registered full). This is
    // what limits the broadcast rate to one beat per two cycles.
    assign s_tready = run_q && ((state_q == IDLE) ||
                                ((state_q == BCAST) && (sent_mask_q == 3'b111)));

    assign m_acc   = m_tvalid & m_tready;
    assign r_acc   = r_tvalid & r_tready;
    assign s_acc   = s_axis_tvalid & s_tready;
    assign dec_acc = (state_q == OUTPUT) & m_axis_dec_tready;

    always_comb begin
        state_d     = state_q;
        beat_data_d = beat_data_q;
        beat_keep_d = beat_keep_q;
        beat_last_d = beat_last_q;
        sent_mask_d = sent_mask_q;
        res_got_d   = res_got_q;
        res_done_d  = res_done_q;
        label_d     = label_q;
        dec_data_d  = dec_data_q;

        case (state_q)
            IDLE: begin
                if (s_acc) begin
                    beat_data_d = s_axis_tdata;
                    beat_keep_d = s_axis_tkeep;
                    beat_last_d = s_axis_tlast;
                    sent_mask_d = 3'b000;
                    res_got_d   = 3'b000;
                    res_done_d  = 3'b000;
                    state_d     = BCAST;
                end
            end

            BCAST: begin
                if (sent_mask_q == 3'b111) begin
                    // Previous non-last beat fully delivered; wait for the next.
                    if (s_acc) begin
                        beat_data_d = s_axis_tdata;
                        beat_keep_d = s_axis_tkeep;
                        beat_last_d = s_axis_tlast;
                        sent_mask_d = 3'b000;
                    end
                end else begin
                    sent_mask_d = sent_mask_q | m_acc;
                    if ((sent_mask_d == 3'b111) && beat_last_q) begin
                        state_d = COLLECT;
                    end
                end
            end

            COLLECT: begin
                for (int i = 0; i < 3; i++) begin
                    if (r_acc[i]) begin
                        if (!res_got_q[i]) begin
                            label_d[i]   = r_tdata[i][CLASS_WIDTH-1:0];
                            res_got_d[i] = 1'b1;
                        end
                        if (r_tlast[i]) begin
                            res_done_d[i] = 1'b1;
                        end
                    end
                end
                // label_d already includes any label captured this cycle,
                // so the decision is registered on the last tlast accept.
                if (res_done_d == 3'b111) begin
                    dec_data_d                    = '0;
                    dec_data_d[CLASS_WIDTH+1:0]   = vote(label_d);
                    state_d                       = OUTPUT;
                end
            end

            OUTPUT: begin
                if (m_axis_dec_tready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            beat_data_q <= '0;
            beat_keep_q <= '0;
            beat_last_q <= 1'b0;
            sent_mask_q <= 3'b000;
            res_got_q   <= 3'b000;
            res_done_q  <= 3'b000;
            label_q     <= '0;
            dec_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            beat_data_q <= beat_data_d;
            beat_keep_q <= beat_keep_d;
            beat_last_q <= beat_last_d;
            sent_mask_q <= sent_mask_d;
            res_got_q   <= res_got_d;
            res_done_q  <= res_done_d;
            label_q     <= label_d;
            dec_data_q  <= dec_data_d;
        end
    end

    assign s_axis_tready = s_tready;

    assign m_axis_tdata_0  = beat_data_q;
    assign m_axis_tkeep_0  = beat_keep_q;
    assign m_axis_tlast_0  = beat_last_q;
    assign m_axis_tvalid_0 = m_tvalid[0];

    assign m_axis_tdata_1  = beat_data_q;
    assign m_axis_tkeep_1  = beat_keep_q;
    assign m_axis_tlast_1  = beat_last_q;
    assign m_axis_tvalid_1 = m_tvalid[1];

    assign m_axis_tdata_2  = beat_data_q;
    assign m_axis_tkeep_2  = beat_keep_q;
    assign m_axis_tlast_2  = beat_last_q;
    assign m_axis_tvalid_2 = m_tvalid[2];

    assign s_axis_res_tready_0 = r_tready[0];
    assign s_axis_res_tready_1 = r_tready[1];
    assign s_axis_res_tready_2 = r_tready[2];

    assign m_axis_dec_tvalid = (state_q == OUTPUT);
    assign m_axis_dec_tdata  = dec_data_q;
    assign m_axis_dec_tkeep  = (state_q == OUTPUT) ? {KEEP_WIDTH{1'b1}} : '0;
    assign m_axis_dec_tlast  = (state_q == OUTPUT);

    assign busy = (state_q != IDLE);

`ifdef ENS_STATS_EN
    logic [31:0] stat_pkts_q, stat_split_q, stat_tie_q;
    logic [1:0]  dec_agree;

    assign dec_agree = dec_data_q[CLASS_WIDTH+1:CLASS_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts_q  <= '0;
            stat_split_q <= '0;
            stat_tie_q   <= '0;
        end else if (dec_acc) begin
            stat_pkts_q <= stat_pkts_q + 32'd1;
            if (dec_agree != 2'd3) begin
                stat_split_q <= stat_split_q + 32'd1;
            end
            if (dec_agree == 2'd1) begin
                stat_tie_q <= stat_tie_q + 32'd1;
            end
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_split = stat_split_q;
    assign stat_tie   = stat_tie_q;
`else
    logic unused_dec_acc;
    assign unused_dec_acc = dec_acc;
`endif

endmodule

// File: tb/tb_ensemble_vote_controller.sv
// ---------------------------------------------------------------------------
// Testbench for ensemble_vote_controller.
// Drives feature packets and classifier results, including random
// back-pressure. Decisions are compared with a counting-based majority
// model, and every branch's received beat sequence is compared with the
// packet that was sent.
// ---------------------------------------------------------------------------
module tb_ensemble_vote_controller;
    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int CW   = 8;
    localparam int TIE  = 2;
    localparam int MAXB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tvalid, s_tready, s_tlast;

    logic [DW-1:0] m_td0, m_td1, m_td2;
    logic [KW-1:0] m_tk0, m_tk1, m_tk2;
    logic          m_tv0, m_tv1, m_tv2, m_tl0, m_tl1, m_tl2;
    logic [2:0]    m_tr;

    logic [DW-1:0] r_td [3];
    logic [KW-1:0] r_tk [3];
    logic [2:0]    r_tv, r_tl;
    logic          r_tr0, r_tr1, r_tr2;

    logic [DW-1:0] d_td;
    logic [KW-1:0] d_tk;
    logic          d_tv, d_tr, d_tl;
    logic          busy;

    logic [2:0]    m_tv, m_tl, r_tr;
    logic [DW-1:0] m_td [3];
    logic [KW-1:0] m_tk [3];
    always_comb begin
        m_tv = {m_tv2, m_tv1, m_tv0};
        m_tl = {m_tl2, m_tl1, m_tl0};
        r_tr = {r_tr2, r_tr1, r_tr0};
        m_td[0] = m_td0; m_td[1] = m_td1; m_td[2] = m_td2;
        m_tk[0] = m_tk0; m_tk[1] = m_tk1; m_tk[2] = m_tk2;
    end

    ensemble_vote_controller #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(CW), .TIE_SEL(TIE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata_0(m_td0), .m_axis_tkeep_0(m_tk0), .m_axis_tvalid_0(m_tv0),
        .m_axis_tready_0(m_tr[0]), .m_axis_tlast_0(m_tl0),
        .m_axis_tdata_1(m_td1), .m_axis_tkeep_1(m_tk1), .m_axis_tvalid_1(m_tv1),
        .m_axis_tready_1(m_tr[1]), .m_axis_tlast_1(m_tl1),
        .m_axis_tdata_2(m_td2), .m_axis_tkeep_2(m_tk2), .m_axis_tvalid_2(m_tv2),
        .m_axis_tready_2(m_tr[2]), .m_axis_tlast_2(m_tl2),
        .s_axis_res_tdata_0(r_td[0]), .s_axis_res_tkeep_0(r_tk[0]), .s_axis_res_tvalid_0(r_tv[0]),
        .s_axis_res_tready_0(r_tr0), .s_axis_res_tlast_0(r_tl[0]),
        .s_axis_res_tdata_1(r_td[1]), .s_axis_res_tkeep_1(r_tk[1]), .s_axis_res_tvalid_1(r_tv[1]),
        .s_axis_res_tready_1(r_tr1), .s_axis_res_tlast_1(r_tl[1]),
        .s_axis_res_tdata_2(r_td[2]), .s_axis_res_tkeep_2(r_tk[2]), .s_axis_res_tvalid_2(r_tv[2]),
        .s_axis_res_tready_2(r_tr2), .s_axis_res_tlast_2(r_tl[2]),
        .m_axis_dec_tdata(d_td), .m_axis_dec_tkeep(d_tk), .m_axis_dec_tvalid(d_tv),
        .m_axis_dec_tready(d_tr), .m_axis_dec_tlast(d_tl),
        .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] pkt_mem [MAXB];
    int            pkt_len;
    logic [DW-1:0] res_mem [3][4];
    int            res_len [3];
    logic [DW-1:0] last_dec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Majority by counting occurrences; a count of one everywhere means tie.
    function automatic logic [DW-1:0] model_dec(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] l [3];
        logic [CW-1:0] win;
        int best, cnt;
        l[0] = a; l[1] = b; l[2] = c;
        best = 0;
        win  = l[TIE];
        for (int i = 0; i < 3; i++) begin
            cnt = 0;
            for (int j = 0; j < 3; j++) if (l[j] == l[i]) cnt++;
            if (cnt > best) begin best = cnt; win = l[i]; end
        end
        if (best == 1) win = l[TIE];
        return (DW'(best) << CW) | DW'(win);
    endfunction

    task automatic set_idle();
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        m_tr = 3'b000; r_tv = 3'b000; r_tl = 3'b000; d_tr = 1'b0;
        for (int i = 0; i < 3; i++) begin r_td[i] = '0; r_tk[i] = '0; end
    endtask

    task automatic rand_inputs();
        s_tvalid = 1'($urandom); s_tdata = $urandom; s_tkeep = KW'($urandom);
        s_tlast = 1'($urandom); m_tr = 3'($urandom); r_tv = 3'($urandom);
        r_tl = 3'($urandom); d_tr = 1'($urandom);
        for (int i = 0; i < 3; i++) begin r_td[i] = $urandom; r_tk[i] = KW'($urandom); end
    endtask

    // Result packet for branch i: n beats, labels l0/l1/l2 in the low bits,
    // random upper bits that must be ignored by the voter.
    task automatic set_res(input int i, input int n, input logic [CW-1:0] l0, l1, l2);
        logic [DW-1:0] v;
        res_len[i] = n;
        for (int j = 0; j < n; j++) begin
            v = $urandom;
            v[CW-1:0] = (j == 0) ? l0 : ((j == 1) ? l1 : l2);
            res_mem[i][j] = v;
        end
    endtask

    task automatic run_pkt(input string nm, input int rdy_pct, input int stall1, input int dec_stall);
        int sp, cyc, nlast, last_cyc, dec_wait;
        bit done;
        int rp [3];
        int rx_cnt [3];
        logic [DW-1:0] rx_data [3][MAXB];
        logic [KW-1:0] rx_keep [3][MAXB];
        logic          rx_last [3][MAXB];
        logic [2:0]    hold;
        logic [DW-1:0] hold_data [3];
        logic          dhold;
        logic [DW-1:0] dhold_data;
        logic [DW-1:0] exp_dec;

        exp_dec = model_dec(res_mem[0][0][CW-1:0], res_mem[1][0][CW-1:0], res_mem[2][0][CW-1:0]);
        sp = 0; cyc = 0; nlast = 0; last_cyc = -10; dec_wait = 0; done = 1'b0;
        hold = 3'b000; dhold = 1'b0; dhold_data = '0;
        for (int i = 0; i < 3; i++) begin rp[i] = 0; rx_cnt[i] = 0; hold_data[i] = '0; end

        while (!done && cyc < 2000) begin
            @(posedge clk); #1;
            if (sp < pkt_len) begin
                s_tvalid = 1'b1; s_tdata = pkt_mem[sp];
                s_tkeep = pkt_mem[sp][KW-1:0]; s_tlast = (sp == pkt_len - 1);
            end else begin
                s_tvalid = 1'b0; s_tdata = $urandom; s_tkeep = '0; s_tlast = 1'($urandom);
            end
            for (int i = 0; i < 3; i++) begin
                if (i == 1 && stall1 > 0 && cyc <= stall1) m_tr[i] = 1'b0;
                else m_tr[i] = ($urandom_range(99) < rdy_pct);
                if (rp[i] < res_len[i]) begin
                    r_tv[i] = 1'b1; r_td[i] = res_mem[i][rp[i]]; r_tl[i] = (rp[i] == res_len[i] - 1);
                end else begin
                    r_tv[i] = 1'b0; r_td[i] = $urandom; r_tl[i] = 1'b0;
                end
                r_tk[i] = KW'($urandom);
            end
            d_tr = (dec_wait >= dec_stall) && ($urandom_range(99) < rdy_pct);

            @(negedge clk);
            chk({nm, "/s_rdy_excl"}, s_tready & ((|m_tv) | d_tv | (|r_tr)), 0);
            chk({nm, "/res_vs_bcast"}, (|r_tr) & (|m_tv), 0);
            for (int i = 0; i < 3; i++) begin
                if (hold[i]) begin
                    chk({nm, "/branch_valid_held"}, m_tv[i], 1);
                    chk({nm, "/branch_data_held"}, m_td[i], hold_data[i]);
                end
            end
            if (dhold) begin
                chk({nm, "/dec_valid_held"}, d_tv, 1);
                chk({nm, "/dec_data_held"}, d_td, dhold_data);
            end
            if (cyc == last_cyc + 1) chk({nm, "/dec_latency"}, d_tv, 1);
            if (stall1 > 0 && cyc == stall1) begin
                chk({nm, "/stall_b1_valid"}, m_tv[1], 1);
                chk({nm, "/stall_b0b2_valid"}, {m_tv[2], m_tv[0]}, 0);
                chk({nm, "/stall_s_tready"}, s_tready, 0);
            end

            if (s_tvalid & s_tready) sp++;
            for (int i = 0; i < 3; i++) begin
                if (m_tv[i] & m_tr[i]) begin
                    if (rx_cnt[i] < MAXB) begin
                        rx_data[i][rx_cnt[i]] = m_td[i];
                        rx_keep[i][rx_cnt[i]] = m_tk[i];
                        rx_last[i][rx_cnt[i]] = m_tl[i];
                    end
                    rx_cnt[i]++;
                end
                hold[i] = m_tv[i] & ~m_tr[i];
                hold_data[i] = m_td[i];
                if (r_tv[i] & r_tr[i]) begin
                    rp[i]++;
                    if (r_tl[i]) begin
                        nlast++;
                        if (nlast == 3) last_cyc = cyc;
                    end
                end
            end
            dhold = d_tv & ~d_tr;
            dhold_data = d_td;
            if (d_tv) begin
                if (d_tr) begin
                    done = 1'b1;
                    last_dec = d_td;
                    chk({nm, "/dec_data"}, d_td, exp_dec);
                    chk({nm, "/dec_keep"}, d_tk, {KW{1'b1}});
                    chk({nm, "/dec_last"}, d_tl, 1);
                end else begin
                    dec_wait++;
                end
            end
            cyc++;
        end

        chk({nm, "/finished_in_budget"}, done, 1);
        for (int i = 0; i < 3; i++) begin
            chk({nm, "/beats_per_branch"}, rx_cnt[i], pkt_len);
            for (int j = 0; j < pkt_len && j < rx_cnt[i] && j < MAXB; j++) begin
                chk({nm, "/beat_data"}, rx_data[i][j], pkt_mem[j]);
                chk({nm, "/beat_keep"}, rx_keep[i][j], pkt_mem[j][KW-1:0]);
                chk({nm, "/beat_last"}, rx_last[i][j], (j == pkt_len - 1));
            end
            chk({nm, "/results_drained"}, rp[i], res_len[i]);
        end
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        chk({nm, "/idle_busy"}, busy, 0);
        chk({nm, "/idle_s_tready"}, s_tready, 1);
    endtask

    initial begin
        int sp;
        set_idle();
        last_dec = '0;

        // Reset held with random inputs
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            rand_inputs();
            @(negedge clk);
            chk("rst_m_tvalid", m_tv, 0);
            chk("rst_res_tready", r_tr, 0);
            chk("rst_s_tready", s_tready, 0);
            chk("rst_dec_tvalid", d_tv, 0);
            chk("rst_busy", busy, 0);
            chk("rst_dec_keep_last", {d_tk, d_tl}, 0);
            chk("rst_data_regs", {m_td0, d_td}, 0);
        end
        @(posedge clk); #1;
        set_idle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_s_tready_before_edge", s_tready, 0);
        @(negedge clk);
        chk("release_s_tready", s_tready, 1);
        chk("release_busy", busy, 0);

        // Four-beat packet, unanimous results
        pkt_len = 4;
        pkt_mem[0] = 32'h11; pkt_mem[1] = 32'h22; pkt_mem[2] = 32'h33; pkt_mem[3] = 32'h44;
        set_res(0, 1, 8'd2, 8'd0, 8'd0);
        set_res(1, 1, 8'd2, 8'd0, 8'd0);
        set_res(2, 1, 8'd2, 8'd0, 8'd0);
        run_pkt("pkt4_agree", 100, 0, 0);
        chk("pkt4_dec_const", last_dec, 32'h0000_0302);

        // Branch 1 stalls on beat 0
        pkt_len = 3;
        pkt_mem[0] = 32'hA1A1_00A1; pkt_mem[1] = 32'hB2B2_00B2; pkt_mem[2] = 32'hC3C3_00C3;
        set_res(0, 1, 8'd4, 8'd0, 8'd0);
        set_res(1, 1, 8'd4, 8'd0, 8'd0);
        set_res(2, 1, 8'd4, 8'd0, 8'd0);
        run_pkt("stall_b1", 100, 5, 0);
        chk("stall_b1_dec_const", last_dec, 32'h0000_0304);

        // Two-of-three majority
        pkt_len = 1;
        pkt_mem[0] = 32'hDEAD_BEEF;
        set_res(0, 1, 8'd1, 8'd0, 8'd0);
        set_res(1, 1, 8'd3, 8'd0, 8'd0);
        set_res(2, 1, 8'd1, 8'd0, 8'd0);
        run_pkt("vote_131", 100, 0, 0);
        chk("vote_131_const", last_dec, 32'h0000_0201);

        // Three-way disagreement uses the tie-break classifier
        set_res(0, 1, 8'd0, 8'd0, 8'd0);
        set_res(1, 1, 8'd1, 8'd0, 8'd0);
        set_res(2, 1, 8'd2, 8'd0, 8'd0);
        run_pkt("vote_tie", 100, 0, 0);
        chk("vote_tie_const", last_dec, 32'h0000_0102);

        // Multi-beat result on branch 0: first label counts, rest drained
        pkt_len = 2;
        pkt_mem[0] = 32'h0102_0304; pkt_mem[1] = 32'h0506_0708;
        set_res(0, 3, 8'd5, 8'd7, 8'd9);
        set_res(1, 1, 8'd5, 8'd0, 8'd0);
        set_res(2, 1, 8'd7, 8'd0, 8'd0);
        run_pkt("multi_res", 100, 0, 0);
        chk("multi_res_const", last_dec, 32'h0000_0205);

        // Decision back-pressure for ten cycles
        pkt_len = 2;
        pkt_mem[0] = 32'h1234_5678; pkt_mem[1] = 32'h9ABC_DEF0;
        set_res(0, 1, 8'd9, 8'd0, 8'd0);
        set_res(1, 1, 8'd8, 8'd0, 8'd0);
        set_res(2, 1, 8'd8, 8'd0, 8'd0);
        run_pkt("dec_stall", 100, 0, 10);
        chk("dec_stall_const", last_dec, 32'h0000_0208);

        // Reset asserted while collecting results
        pkt_len = 2;
        pkt_mem[0] = 32'h5555_0001; pkt_mem[1] = 32'h5555_0002;
        sp = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            s_tvalid = (sp < pkt_len);
            s_tdata  = (sp < pkt_len) ? pkt_mem[sp] : '0;
            s_tkeep  = '1;
            s_tlast  = (sp == pkt_len - 1);
            m_tr = 3'b111; r_tv = 3'b000; d_tr = 1'b0;
            @(negedge clk);
            if (s_tvalid & s_tready) sp++;
        end
        chk("mid_collect_busy", busy, 1);
        chk("mid_collect_res_tready", r_tr, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_m_tvalid", m_tv, 0);
        chk("arst_res_tready", r_tr, 0);
        chk("arst_dec_tvalid", d_tv, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_tready", s_tready, 0);
        @(posedge clk); #1;
        set_idle();
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_arst_s_tready", s_tready, 1);

        // Randomized packets with random back-pressure
        for (int p = 0; p < 25; p++) begin
            pkt_len = $urandom_range(1, 6);
            for (int j = 0; j < pkt_len; j++) pkt_mem[j] = $urandom;
            for (int i = 0; i < 3; i++) begin
                set_res(i, $urandom_range(1, 3), CW'($urandom_range(0, 3)),
                        CW'($urandom), CW'($urandom));
            end
            run_pkt("random", $urandom_range(40, 100), 0, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
